// File: rtl/uart_tx_frame.sv
// UART transmit framer: one start bit, eight data bits LSB first, one stop bit.
// Each bit is held for CLKS_PER_BIT clocks; serial_out is always driven from a flop.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;

  assign bit_end = (clk_cnt == LAST_CNT);
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (tx_start) begin
            shreg      <= tx_data;
            serial_out <= 1'b0;
            clk_cnt    <= '0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            serial_out <= shreg[0];
            shreg      <= {1'b0, shreg[7:1]};
            clk_cnt    <= '0;
            bit_idx    <= '0;
            state      <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx != 3'd7) begin
              serial_out <= shreg[0];
              shreg      <= {1'b0, shreg[7:1]};
              bit_idx    <= bit_idx + 3'd1;
            end else begin
              serial_out <= 1'b1;
              state      <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          serial_out <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          serial_out <= 1'b1;
          clk_cnt    <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
